// File: rtl/conv_ofmap_collect.sv
// Collects one convolution output frame in raster order, quantizes each pixel
// and emits a registered write stream to the output feature-map memory.
module conv_ofmap_collect #(
  parameter int O_CONV_BW    = 20,
  parameter int O_BW         = 8,
  parameter int IF_SIZE_CONV = 28,
  parameter int K_SIZE       = 5,
  parameter int SHIFT        = 4,
  parameter int ADDR_BW      = 10
) (
  input  logic                        clk,
  input  logic                        global_rst_n,
  input  logic                        i_start,
  input  logic signed [O_CONV_BW-1:0] i_conv_result,
  input  logic                        i_valid_conv,
  output logic                        o_wr_en,
  output logic        [ADDR_BW-1:0]   o_wr_addr,
  output logic        [O_BW-1:0]      o_wr_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err_overrun
);

  localparam int OF_SIZE = IF_SIZE_CONV - K_SIZE + 1;
  localparam int NPIX    = OF_SIZE * OF_SIZE;
  localparam int RC_BW   = (OF_SIZE > 1) ? $clog2(OF_SIZE) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic   [RC_BW-1:0]          r_row;
  logic   [RC_BW-1:0]          r_col;
  logic   [ADDR_BW-1:0]        r_addr;
  logic                        w_start;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_col_wrap;
  logic signed [O_CONV_BW-1:0] w_shifted;
  logic   [O_BW-1:0]           w_quant;

  // A start is only honoured outside COLLECT, including the single DONE cycle.
  assign w_start    = i_start && (r_state != S_COLLECT);
  assign w_accept   = i_valid_conv && (r_state == S_COLLECT);
  assign w_last     = w_accept && (r_addr == ADDR_BW'(NPIX - 1));
  assign w_col_wrap = (r_col == RC_BW'(OF_SIZE - 1));

  assign w_shifted = i_conv_result >>> SHIFT;

  always_comb begin
    w_quant = w_shifted[O_BW-1:0];
    if (i_conv_result[O_CONV_BW-1]) begin
      w_quant = '0;
    end else if (|w_shifted[O_CONV_BW-1:O_BW]) begin
      w_quant = {O_BW{1'b1}};
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next_state = S_COLLECT;
      S_COLLECT: if (w_last)  w_next_state = S_DONE;
      S_DONE:    w_next_state = w_start ? S_COLLECT : S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Counters wrap to zero after the final pixel so the address never passes NPIX-1.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (w_start || w_last) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= r_addr + ADDR_BW'(1);
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= r_row + RC_BW'(1);
      end else begin
        r_col <= r_col + RC_BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      o_wr_en <= w_accept;
      if (w_accept) begin
        o_wr_addr <= r_addr;
        o_wr_data <= w_quant;
      end
    end
  end

  // Sticky overrun: a start clears it even if a stray valid arrives alongside.
  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      o_err_overrun <= 1'b0;
    end else if (w_start) begin
      o_err_overrun <= 1'b0;
    end else if (i_valid_conv && (r_state != S_COLLECT)) begin
      o_err_overrun <= 1'b1;
    end
  end

  assign o_busy = (r_state == S_COLLECT);
  assign o_done = (r_state == S_DONE);

endmodule

// File: doc/conv_ofmap_collect.md
CONV_OFMAP_COLLECT -- requirements
Module: conv_ofmap_collect

Interface
REQ-001 Parameter O_CONV_BW, default 20, SHALL be the width of the signed convolution result input.
REQ-002 Parameter O_BW, default 8, SHALL be the width of the unsigned quantized output pixel.
REQ-003 Parameter IF_SIZE_CONV, default 28, SHALL be the input feature-map side length.
REQ-004 Parameter K_SIZE, default 5, SHALL be the kernel side length; OF_SIZE = IF_SIZE_CONV-K_SIZE+1 (24 by default).
REQ-005 Parameter SHIFT, default 4, SHALL be the arithmetic right-shift applied before saturation.
REQ-006 Parameter ADDR_BW, default 10, SHALL be the write-address width; it must satisfy 2^ADDR_BW >= OF_SIZE^2.
REQ-007 clk  input  1  SHALL be the single clock; all state changes occur on the rising edge.
REQ-008 global_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-009 i_start  input  1  SHALL be the single-cycle pulse that arms collection of one output frame.
REQ-010 i_conv_result  input  O_CONV_BW  SHALL be the signed convolution sum.
REQ-011 i_valid_conv  input  1  SHALL qualify i_conv_result for one cycle per output pixel, in raster order.
REQ-012 o_wr_en  output  1  SHALL be the output-memory write strobe.
REQ-013 o_wr_addr  output  ADDR_BW  SHALL be the linear address row*OF_SIZE+col.
REQ-014 o_wr_data  output  O_BW  SHALL be the quantized pixel.
REQ-015 o_busy  output  1  SHALL be high while in COLLECT.
REQ-016 o_done  output  1  SHALL be a one-cycle pulse marking frame completion.
REQ-017 o_err_overrun  output  1  SHALL be a sticky flag for valids that arrive outside COLLECT.

Function
REQ-018 The FSM SHALL have the states IDLE, COLLECT and DONE; the reset state SHALL be IDLE.
REQ-019 IDLE->COLLECT SHALL occur on i_start; the row and column counters SHALL clear to 0 and o_err_overrun SHALL clear.
REQ-020 i_start SHALL be ignored while in COLLECT.
REQ-021 In COLLECT, each i_valid_conv SHALL produce o_wr_en=1 exactly one cycle later, with o_wr_addr and o_wr_data registered.
REQ-022 Quantization: if i_conv_result<0 the output SHALL be 0; otherwise it SHALL be (i_conv_result>>>SHIFT), saturated to 2^O_BW-1.
REQ-023 Column counter: col SHALL advance on each accepted valid; at OF_SIZE-1 it SHALL wrap to 0 and row SHALL increment.
REQ-024 The address counter SHALL increment by 1 per accepted valid and SHALL never exceed OF_SIZE^2-1.
REQ-025 An accepted valid at address OF_SIZE^2-1 SHALL move the FSM to DONE; in that cycle o_wr_en=1 for the last pixel.
REQ-026 DONE SHALL last exactly one cycle with o_done=1 and o_busy=0, then go to IDLE.
REQ-027 An i_start in the DONE cycle SHALL be accepted: next state COLLECT, counters cleared.
REQ-028 An i_valid_conv in IDLE or DONE SHALL not be written and SHALL set o_err_overrun, which holds until the next accepted i_start.
REQ-029 A cycle without a valid in COLLECT SHALL hold the counters and force o_wr_en=0; gaps of any length SHALL be tolerated.
REQ-030 o_wr_addr and o_wr_data SHALL hold their last values when o_wr_en=0.

Reset
REQ-031 On global_rst_n low, regardless of clk: FSM=IDLE; row, col and address=0; o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done and o_err_overrun all =0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait in IDLE for i_start.

Verification
REQ-033 i_start, then 576 back-to-back valids with result=100 -> 576 writes, addr 0..575, data 6, o_done one cycle after the write to addr 575, then o_busy=0.
REQ-034 Valids with results -7, 5000 and 4095 -> o_wr_data 0, 255 and 255.
REQ-035 Valids with a 3-cycle gap after every 24th valid -> addresses contiguous, o_wr_en low during the gaps, col wraps 23->0.
REQ-036 A valid in IDLE before i_start -> no write, o_err_overrun=1; the next i_start clears it to 0.
REQ-037 global_rst_n pulsed low after 100 writes -> all outputs 0 immediately; then i_start plus 576 valids -> addresses start again at 0.
REQ-038 i_start asserted in the DONE cycle -> o_busy=1 on the next cycle and the first write goes to addr 0.
